// File: rtl/insn_fetch_unit.sv
// insn_fetch_unit: instruction fetch stage between the PC and decode.
// Keeps at most one instruction-memory request in flight, parks the returned
// word in a one-entry buffer for decode, tells the PC when to step, and
// throws away buffered or in-flight words on a flush (branch redirect).
module insn_fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int INSN_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pcIn,
  output logic                  pcAdvance,
  input  logic                  flush,
  output logic                  imemReqValid,
  output logic [ADDR_WIDTH-1:0] imemReqAddr,
  input  logic                  imemReqReady,
  input  logic                  imemRespValid,
  input  logic [INSN_WIDTH-1:0] imemRespData,
  output logic                  insnValid,
  output logic [INSN_WIDTH-1:0] insnOut,
  output logic [ADDR_WIDTH-1:0] insnAddrOut,
  input  logic                  insnReady
);

  typedef enum logic {
    S_REQ  = 1'b0,  // free to issue the next request
    S_WAIT = 1'b1   // one request outstanding, waiting for its response
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_buf_valid;
  logic [INSN_WIDTH-1:0] r_buf_insn;
  logic [ADDR_WIDTH-1:0] r_buf_addr;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic                  r_kill;   // the outstanding response belongs to a flushed path

  logic w_can_issue;
  logic w_req_fire;
  logic w_resp_fire;
  logic w_fill;
  logic w_xfer;

  // A new word may only be requested if the buffer will be free to take it.
  // Outputs are forced low while reset is held so nothing leaks out during reset.
  assign insnValid    = r_buf_valid && !flush && rst;
  assign insnOut      = r_buf_insn;
  assign insnAddrOut  = r_buf_addr;
  assign imemReqAddr  = pcIn;
  assign w_xfer       = insnValid && insnReady;
  assign w_can_issue  = !r_buf_valid || w_xfer;
  assign w_req_fire   = imemReqValid && imemReqReady;
  // A response is only meaningful while waiting; stray ones in S_REQ are ignored.
  assign w_resp_fire  = (r_state == S_WAIT) && imemRespValid;
  assign w_fill       = w_resp_fire && !r_kill && !flush;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_REQ;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of block evaluation order.
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: leave S_REQ on an accepted request, leave S_WAIT on its response.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    case (r_state)
      S_REQ:  if (w_req_fire)    w_state_nxt = S_WAIT;
      S_WAIT: if (imemRespValid) w_state_nxt = S_REQ;
    endcase
  end

  // FSM outputs: request when the buffer has room and no flush; PC steps on acceptance.
  always_comb begin
    imemReqValid = 1'b0;
    pcAdvance    = 1'b0;
    if (r_state == S_REQ) begin
      imemReqValid = w_can_issue && !flush && rst;
      pcAdvance    = imemReqValid && imemReqReady;
    end
  end

  // Remember the address of the outstanding request so the word can be tagged with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_addr <= '0;
    end else if (w_req_fire) begin
      r_req_addr <= pcIn;
    end
  end

  // Kill flag: a flush during S_WAIT marks the pending response as dead; it
  // clears when that response arrives, whether or not another flush coincides.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_kill <= 1'b0;
    end else if (w_resp_fire) begin
      r_kill <= 1'b0;
    end else if ((r_state == S_WAIT) && flush) begin
      r_kill <= 1'b1;
    end
  end

  // Output buffer valid: flush clears it, a fill beats a same-edge drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf_valid <= 1'b0;
    end else if (flush) begin
      r_buf_valid <= 1'b0;
    end else if (w_fill) begin
      r_buf_valid <= 1'b1;
    end else if (w_xfer) begin
      r_buf_valid <= 1'b0;
    end
  end

  // Output buffer payload: captured only on a live response, held otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf_insn <= '0;
      r_buf_addr <= '0;
    end else if (w_fill) begin
      r_buf_insn <= imemRespData;
      r_buf_addr <= r_req_addr;
    end
  end

endmodule

// File: tb/tb_insn_fetch_unit.sv
// Testbench for insn_fetch_unit: the bench plays PC, instruction memory and
// decode. The reference model works in program-order terms: every word
// delivered to decode must be the next sequential address since the last
// redirect (or reset), carrying that address's memory contents; anything in
// flight or buffered when a flush occurs must never surface.
module tb_insn_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcIn;
  logic        pcAdvance;
  logic        flush;
  logic        imemReqValid;
  logic [31:0] imemReqAddr;
  logic        imemReqReady;
  logic        imemRespValid;
  logic [31:0] imemRespData;
  logic        insnValid;
  logic [31:0] insnOut;
  logic [31:0] insnAddrOut;
  logic        insnReady;

  insn_fetch_unit #(.ADDR_WIDTH(32), .INSN_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .pcIn         (pcIn),
    .pcAdvance    (pcAdvance),
    .flush        (flush),
    .imemReqValid (imemReqValid),
    .imemReqAddr  (imemReqAddr),
    .imemReqReady (imemReqReady),
    .imemRespValid(imemRespValid),
    .imemRespData (imemRespData),
    .insnValid    (insnValid),
    .insnOut      (insnOut),
    .insnAddrOut  (insnAddrOut),
    .insnReady    (insnReady)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
    bit          killed;
  } mem_ent_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          deadbeef = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] exp_addr = '0;
  mem_ent_t    q[$];
  int          n_accept = 0;
  int          last_acc_cyc = 0;
  logic [31:0] last_acc_addr = '0;
  int          n_deliv = 0;
  int          deliv_cyc[$];
  logic [31:0] deliv_addr[$];
  bit          hold_prev = 1'b0;
  logic [31:0] hold_addr = '0;
  logic [31:0] hold_insn = '0;
  bit          resp_pend = 1'b0;
  bit          resp_good = 1'b0;
  logic [31:0] resp_addr = '0;
  logic [31:0] resp_data = '0;
  logic        obs_req_valid = 1'b0;
  logic [31:0] obs_req_addr = '0;
  logic        obs_pc_adv = 1'b0;
  logic        obs_insn_valid = 1'b0;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory side: present the head response once its latency has elapsed.
  task automatic drive_mem();
    if (q.size() != 0 && q[0].due <= cyc) begin
      imemRespValid = 1'b1;
      imemRespData  = q[0].data;
    end else begin
      imemRespValid = 1'b0;
      imemRespData  = '0;
    end
  endtask

  // Sample the DUT mid-cycle, check it against the model, then advance the model.
  task automatic observe();
    mem_ent_t e;
    obs_req_valid  = imemReqValid;
    obs_req_addr   = imemReqAddr;
    obs_pc_adv     = pcAdvance;
    obs_insn_valid = insnValid;

    if (imemReqValid) check("req_addr", imemReqAddr, pcIn);
    check("pc_advance", 32'(pcAdvance), 32'(imemReqValid && imemReqReady));
    if (q.size() != 0) begin
      check("one_outstanding", 32'(imemReqValid), 32'(0));
      check("wait_buf_empty", 32'(insnValid), 32'(0));
    end
    if (flush) begin
      check("flush_no_insn", 32'(insnValid), 32'(0));
      check("flush_no_req", 32'(imemReqValid), 32'(0));
    end
    if (insnValid && !insnReady) check("stall_no_req", 32'(imemReqValid), 32'(0));
    if (hold_prev && !flush) begin
      check("hold_valid", 32'(insnValid), 32'(1));
      check("hold_addr", insnAddrOut, hold_addr);
      check("hold_insn", insnOut, hold_insn);
    end
    if (resp_pend && !flush) begin
      if (resp_good) begin
        check("resp_valid", 32'(insnValid), 32'(1));
        check("resp_addr", insnAddrOut, resp_addr);
        check("resp_insn", insnOut, resp_data);
      end else begin
        check("dropped_word", 32'(insnValid), 32'(0));
      end
    end
    resp_pend = 1'b0;

    if (insnValid && insnReady) begin
      check("deliv_addr", insnAddrOut, exp_addr);
      check("deliv_insn", insnOut, mem_data(exp_addr));
      exp_addr = exp_addr + 32'd4;
      n_deliv++;
      deliv_cyc.push_back(cyc);
      deliv_addr.push_back(insnAddrOut);
    end

    if (imemRespValid && q.size() != 0) begin
      e = q.pop_front();
      resp_pend = 1'b1;
      resp_good = !e.killed && !flush;
      resp_addr = e.addr;
      resp_data = e.data;
    end
    if (flush) begin
      for (int i = 0; i < q.size(); i++) begin
        e = q[i];
        e.killed = 1'b1;
        q[i] = e;
      end
      exp_addr = redirect_pc;
    end
    if (imemReqValid && imemReqReady) begin
      e.addr   = imemReqAddr;
      e.data   = deadbeef ? 32'hDEAD_BEEF : mem_data(imemReqAddr);
      e.due    = cyc + lat;
      e.killed = 1'b0;
      q.push_back(e);
      n_accept++;
      last_acc_cyc  = cyc;
      last_acc_addr = imemReqAddr;
    end

    hold_prev = insnValid && !insnReady;
    hold_addr = insnAddrOut;
    hold_insn = insnOut;

    if (flush) pc = redirect_pc;
    else if (pcAdvance) pc = pc + 32'd4;
  endtask

  task automatic cycle();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cyc++;
    pcIn = pc;
    drive_mem();
  endtask

  // Stop issuing and let everything in flight drain to decode.
  task automatic quiesce();
    int n = 0;
    imemReqReady = 1'b0;
    insnReady    = 1'b1;
    flush        = 1'b0;
    do begin
      cycle();
      n++;
    end while ((q.size() != 0 || obs_insn_valid || resp_pend) && n < 40);
    check("quiesce_timeout", 32'(n < 40), 32'(1));
  endtask

  task automatic wait_deliv(input int nb, input string tag);
    int n = 0;
    while (n_deliv == nb && n < 30) begin
      cycle();
      n++;
    end
    check(tag, 32'(n_deliv > nb), 32'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int nb;
    int acc_c;

    rst = 1'b1; flush = 1'b0; pcIn = '0; imemReqReady = 1'b0;
    imemRespValid = 1'b0; imemRespData = '0; insnReady = 1'b0;
    #1 rst = 1'b0;

    // Reset: all outputs low while held.
    repeat (3) begin
      @(negedge clk);
      check("rst_req_valid", 32'(imemReqValid), 32'(0));
      check("rst_pc_adv", 32'(pcAdvance), 32'(0));
      check("rst_insn_valid", 32'(insnValid), 32'(0));
    end

    // Release; 1-cycle memory, decode always ready: 0x0, 0x4, 0x8 one per 2 cycles.
    @(posedge clk); #1;
    rst = 1'b1; pc = '0; pcIn = '0; exp_addr = '0;
    imemReqReady = 1'b1; insnReady = 1'b1; lat = 1;
    start = cyc; nb = n_deliv;
    drive_mem();
    repeat (7) cycle();
    check("seq_count", 32'(n_deliv - nb), 32'(3));
    for (int k = 0; k < 3; k++) begin
      if (n_deliv - nb > k) begin
        check("seq_addr", deliv_addr[nb + k], 32'(4 * k));
        check("seq_cycle", 32'(deliv_cyc[nb + k]), 32'(start + 2 + 2 * k));
      end
    end

    // Memory not ready for 2 cycles, then 4-cycle latency.
    quiesce();
    lat = 4;
    nb = n_deliv;
    start = n_accept;
    repeat (2) begin
      cycle();
      check("nordy_req_valid", 32'(obs_req_valid), 32'(1));
      check("nordy_req_addr", obs_req_addr, pc);
      check("nordy_pc_adv", 32'(obs_pc_adv), 32'(0));
    end
    imemReqReady = 1'b1;
    cycle();
    check("nordy_accept", 32'(n_accept), 32'(start + 1));
    acc_c = last_acc_cyc;
    wait_deliv(nb, "lat4_timeout");
    if (n_deliv > nb) check("lat4_latency", 32'(deliv_cyc[nb] - acc_c), 32'(5));

    // Decode stalls 5 cycles with the buffer full.
    quiesce();
    lat = 1; insnReady = 1'b0; imemReqReady = 1'b1;
    cycle();
    acc_c = last_acc_cyc;
    cycle();
    repeat (5) begin
      cycle();
      check("stall_insn_valid", 32'(obs_insn_valid), 32'(1));
      check("stall_req_valid", 32'(obs_req_valid), 32'(0));
      check("stall_pc_adv", 32'(obs_pc_adv), 32'(0));
    end
    insnReady = 1'b1;
    nb = n_deliv;
    cycle();
    check("unstall_req_valid", 32'(obs_req_valid), 32'(1));
    check("unstall_pc_adv", 32'(obs_pc_adv), 32'(1));
    check("unstall_deliv", 32'(n_deliv), 32'(nb + 1));

    // Flush while waiting; the dead word (0xDEADBEEF) arrives 2 cycles later.
    quiesce();
    lat = 3; imemReqReady = 1'b1; deadbeef = 1'b1;
    cycle();
    deadbeef = 1'b0;
    flush = 1'b1; redirect_pc = 32'h100;
    cycle();
    flush = 1'b0;
    nb = n_deliv;
    cycle();
    cycle();
    check("fwait_resp_taken", 32'(q.size()), 32'(0));
    cycle();
    check("fwait_dropped", 32'(obs_insn_valid), 32'(0));
    check("fwait_req_valid", 32'(obs_req_valid), 32'(1));
    check("fwait_req_addr", last_acc_addr, 32'h100);
    wait_deliv(nb, "fwait_timeout");
    if (n_deliv > nb) check("fwait_deliv_addr", deliv_addr[nb], 32'h100);

    // Flush in the same cycle as the response.
    quiesce();
    lat = 2; imemReqReady = 1'b1;
    cycle();
    cycle();
    flush = 1'b1; redirect_pc = 32'h180;
    cycle();
    check("fresp_insn_valid", 32'(obs_insn_valid), 32'(0));
    check("fresp_req_valid", 32'(obs_req_valid), 32'(0));
    check("fresp_resp_taken", 32'(q.size()), 32'(0));
    flush = 1'b0;
    nb = n_deliv;
    cycle();
    check("fresp_dropped", 32'(obs_insn_valid), 32'(0));
    check("fresp_req_addr", last_acc_addr, 32'h180);
    wait_deliv(nb, "fresp_timeout");
    if (n_deliv > nb) check("fresp_deliv_addr", deliv_addr[nb], 32'h180);

    // Flush while a buffered word would transfer to decode.
    quiesce();
    lat = 1; imemReqReady = 1'b1; insnReady = 1'b1;
    cycle();
    cycle();
    flush = 1'b1; redirect_pc = 32'h200;
    nb = n_deliv;
    cycle();
    check("fbuf_insn_valid", 32'(obs_insn_valid), 32'(0));
    check("fbuf_req_valid", 32'(obs_req_valid), 32'(0));
    check("fbuf_no_deliv", 32'(n_deliv), 32'(nb));
    flush = 1'b0;
    cycle();
    check("fbuf_cleared", 32'(obs_insn_valid), 32'(0));
    check("fbuf_req_addr", last_acc_addr, 32'h200);
    wait_deliv(nb, "fbuf_timeout");
    if (n_deliv > nb) check("fbuf_deliv_addr", deliv_addr[nb], 32'h200);

    // Asynchronous reset in the middle of a wait, then a stray response.
    quiesce();
    lat = 4; imemReqReady = 1'b1;
    cycle();
    cycle();
    #2 rst = 1'b0;
    #1;
    check("arst_req_valid", 32'(imemReqValid), 32'(0));
    check("arst_pc_adv", 32'(pcAdvance), 32'(0));
    check("arst_insn_valid", 32'(insnValid), 32'(0));
    q.delete();
    resp_pend = 1'b0; hold_prev = 1'b0;
    pc = 32'h300; pcIn = 32'h300; exp_addr = 32'h300;
    imemRespValid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("arst_hold_req", 32'(imemReqValid), 32'(0));
      check("arst_hold_insn", 32'(insnValid), 32'(0));
    end
    @(posedge clk); #1;
    cyc++;
    rst = 1'b1; imemReqReady = 1'b0; insnReady = 1'b1;
    imemRespValid = 1'b1; imemRespData = 32'h1234_5678;
    cycle();
    check("stray_req_valid", 32'(obs_req_valid), 32'(1));
    imemReqReady = 1'b1;
    nb = n_deliv;
    cycle();
    check("stray_ignored", 32'(obs_insn_valid), 32'(0));
    check("restart_req_addr", last_acc_addr, 32'h300);
    wait_deliv(nb, "restart_timeout");
    if (n_deliv > nb) check("restart_deliv_addr", deliv_addr[nb], 32'h300);

    // Randomized traffic: backpressure on both sides, variable latency, flushes.
    nb = n_deliv;
    for (int i = 0; i < 400; i++) begin
      imemReqReady = ($urandom_range(0, 3) != 0);
      insnReady    = ($urandom_range(0, 9) < 7);
      lat          = int'($urandom_range(1, 4));
      flush        = ($urandom_range(0, 19) == 0);
      if (flush) redirect_pc = 32'($urandom_range(0, 1023)) << 2;
      cycle();
    end
    flush = 1'b0;
    quiesce();
    check("rand_progress", 32'(n_deliv - nb > 20), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/insn_fetch_unit.md
# insn_fetch_unit

Instruction fetch stage between the program counter and decode. Each cycle it may take the current PC value, issue a single-outstanding request to instruction memory over a valid/ready handshake and capture the returned word in a one-entry output buffer. It presents the word to decode with valid/ready. It tells the PC when to advance and discards in-flight or buffered instructions on a pipeline flush (branch redirect).

## Interface
- ADDR_WIDTH, 32, instruction address width (matches InsnAddrPath)
- INSN_WIDTH, 32, instruction word width
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- pcIn  in  ADDR_WIDTH  current PC value (PC addrOut)
- pcAdvance  out  1  one-cycle pulse: PC must step to its next address this edge; PC holds otherwise
- flush  in  1  kill all fetch-side state (redirect is written to the PC separately)
- imemReqValid  out  1  request valid
- imemReqAddr  out  ADDR_WIDTH  request address (= pcIn while imemReqValid)
- imemReqReady  in  1  memory accepts request
- imemRespValid  in  1  response valid; one response per accepted request, in order, latency ≥1 cycle
- imemRespData  in  INSN_WIDTH  instruction word
- insnValid  out  1  instruction available to decode
- insnOut  out  INSN_WIDTH  instruction word
- insnAddrOut  out  ADDR_WIDTH  address the word was fetched from
- insnReady  in  1  decode accepts instruction

## Operation
- State: FSM {REQ, WAIT}; output buffer (bufValid, bufInsn, bufAddr); outstanding address reg reqAddr; kill flag.
- canIssue = !bufValid || (insnValid && insnReady).
- REQ: imemReqValid = canIssue && !flush. On imemReqValid && imemReqReady: reqAddr <= pcIn, pcAdvance = 1 (same cycle, combinational), go WAIT. Otherwise stay REQ, pcAdvance = 0.
- WAIT: imemReqValid = 0. On imemRespValid: if kill or flush, drop word; else bufValid <= 1, bufInsn <= imemRespData, bufAddr <= reqAddr. Clear kill; go REQ. Without response: stay WAIT; flush sets kill.
- imemRespValid outside WAIT is ignored.
- insnValid = bufValid && !flush; insnOut = bufInsn; insnAddrOut = bufAddr. Transfer = insnValid && insnReady → bufValid <= 0 unless refilled same edge.
- flush: bufValid <= 0 (no transfer counted in flush cycle); no request issued in flush cycle; outstanding response, if any, discarded via kill. Flush while kill already set: kill stays set. Fetch resumes from the redirected pcIn the cycle after flush.
- Simultaneous buffer drain and response fill: fill wins, bufValid stays 1 with new word.

## Timing
- Reset (rst low, async): state REQ, bufValid 0, kill 0, reqAddr 0, bufInsn 0, bufAddr 0; outputs imemReqValid 0, pcAdvance 0, insnValid 0 while rst low. First request may assert the first cycle after rst deasserts.
- Request accepted cycle N → pcAdvance high in N, PC shows next address at N+1.
- Response at cycle M ≥ N+1 → insnValid high from M+1.
- Next request earliest M+1 (state REQ), requiring canIssue. With 1-cycle memory and decode always ready: one instruction every 2 cycles.
- Decode stall: bufValid holds insnOut/insnAddrOut stable until transfer; no request is issued while buffer full and not draining, so PC holds.
- Reset asserted mid-WAIT: outstanding request forgotten; a late response (arriving in REQ) is ignored; the memory model must also be reset.

## Test plan
- Reset release, pcIn=0x0, ready memory, 1-cycle latency, decode ready → reqAddr 0x0, pcAdvance in accept cycle, insnValid with insnAddrOut 0x0 two cycles after accept; sequence 0x0,0x4,0x8 delivered in order, one per 2 cycles.
- Memory latency 4 cycles, imemReqReady low 2 cycles → imemReqValid held with stable address, pcAdvance only on acceptance, exactly one outstanding request.
- Decode insnReady low 5 cycles with buffer full → insnOut/insnAddrOut stable, no new request, no pcAdvance; on insnReady high, request issued same cycle.
- Flush in WAIT (response 2 cycles later, data 0xDEADBEEF) → word dropped, insnValid stays 0; next request uses redirected pcIn 0x100 and delivers insnAddrOut 0x100.
- Flush coincident with imemRespValid, and flush while insnValid && insnReady → word dropped / buffer cleared, insnValid low in flush cycle, no request in flush cycle.
- rst low asynchronously mid-WAIT → all outputs 0 immediately; stray response after release ignored; fetch restarts from pcIn.
